// File: rtl/mole_game_if.sv
// mole_game_if
//   Groups the game engine's input controls and display/score outputs.
//   Signals:
//     start      new-game pulse from the control front end
//     hit_in     debounced, clk-synchronous button levels (one per hole)
//     mole_out   mole LEDs: one-hot while a mole is up, all ones when over
//     score      correct-hit count (saturating)
//     misses     miss count (wrong hole or timeout)
//     hit_pulse  one-cycle pulse per scored hit
//     game_over  high while the game is over
//   Modports:
//     master  front end / display side (drives start and hit_in)
//     slave   the game engine (drives the outputs)
interface mole_game_if #(
  parameter int N_HOLES = 4,
  parameter int SCORE_W = 4,
  parameter int MISS_W  = 2
);
  logic               start;
  logic [N_HOLES-1:0] hit_in;
  logic [N_HOLES-1:0] mole_out;
  logic [SCORE_W-1:0] score;
  logic [MISS_W-1:0]  misses;
  logic               hit_pulse;
  logic               game_over;

  modport master (
    output start, hit_in,
    input  mole_out, score, misses, hit_pulse, game_over
  );

  modport slave (
    input  start, hit_in,
    output mole_out, score, misses, hit_pulse, game_over
  );
endinterface

// File: rtl/mole_game_core.sv
// mole_game_core
//   Whack-a-mole game engine. Raises one pseudo-randomly chosen mole at a time
//   for a bounded window, scores correct hits, counts misses (wrong hole or
//   timeout) and ends the game after MAX_MISSES misses.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    mole_game_if.slave: start, hit_in in; mole_out, score, misses,
//            hit_pulse, game_over out (all outputs registered)
module mole_game_core #(
  parameter int         N_HOLES    = 4,
  parameter int         SCORE_W    = 4,
  parameter int         UP_CYCLES  = 16,
  parameter int         GAP_CYCLES = 4,
  parameter int         MAX_MISSES = 3,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input logic        clk,
  input logic        rst_n,
  mole_game_if.slave bus
);

  localparam int MISS_W = $clog2(MAX_MISSES + 1);
  localparam int HOLE_W = $clog2(N_HOLES);
  localparam int TMR_MAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int TMR_W  = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [HOLE_W-1:0]  prev_hole_q, prev_hole_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [N_HOLES-1:0] hit_q;
  logic               ready_q;
  logic [N_HOLES-1:0] mole_q, mole_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               game_over_q, game_over_d;

  logic [N_HOLES-1:0] rise_s;
  logic [N_HOLES-1:0] tgt_s;
  logic [N_HOLES-1:0] sel_onehot_s;
  logic [7:0]         idx_raw_s;
  logic [7:0]         idx_sel_s;
  logic [HOLE_W-1:0]  hole_sel_s;
  logic [MISS_W-1:0]  misses_inc_s;
  logic               good_s;
  logic               wrong_s;
  logic               timeout_s;

  // One-hot mask for a hole index.
  function automatic logic [N_HOLES-1:0] onehot(input logic [HOLE_W-1:0] idx);
    onehot = {{(N_HOLES-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Button edge detect, target mask, hit classification and next-hole choice.
  always_comb begin
    rise_s       = bus.hit_in & ~hit_q;
    tgt_s        = onehot(prev_hole_q);
    good_s       = |(rise_s & tgt_s);
    wrong_s      = |(rise_s & ~tgt_s);
    timeout_s    = (timer_q == TMR_W'(UP_CYCLES - 1));
    misses_inc_s = misses_q + MISS_W'(1'b1);
    lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    idx_raw_s    = lfsr_q % 8'(N_HOLES);
    // Bump past the previous hole so the same hole never comes up twice in a row.
    if (idx_raw_s == 8'(prev_hole_q)) begin
      idx_sel_s = (idx_raw_s == 8'(N_HOLES - 1)) ? 8'd0 : (idx_raw_s + 8'd1);
    end else begin
      idx_sel_s = idx_raw_s;
    end
    hole_sel_s   = HOLE_W'(idx_sel_s);
    sel_onehot_s = onehot(hole_sel_s);
  end

  // Game FSM next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    prev_hole_d = prev_hole_q;
    mole_d      = mole_q;
    score_d     = score_q;
    misses_d    = misses_q;
    hit_pulse_d = 1'b0;
    game_over_d = game_over_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        // ready_q masks a start that coincides with reset release.
        if (bus.start && ready_q) begin
          state_d     = S_GAP;
          timer_d     = {TMR_W{1'b0}};
          score_d     = {SCORE_W{1'b0}};
          misses_d    = {MISS_W{1'b0}};
          mole_d      = {N_HOLES{1'b0}};
          game_over_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_GAP: begin
        mole_d = {N_HOLES{1'b0}};
        if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
          state_d     = S_UP;
          timer_d     = {TMR_W{1'b0}};
          prev_hole_d = hole_sel_s;
          mole_d      = sel_onehot_s;
        end else begin
          timer_d = timer_q + TMR_W'(1'b1);
        end
      end
      S_UP: begin
        // Any wrong rise wins over a simultaneous correct rise; a correct
        // rise on the last cycle beats the timeout.
        if (wrong_s || (!good_s && timeout_s)) begin
          misses_d = misses_inc_s;
          timer_d  = {TMR_W{1'b0}};
          if (misses_inc_s == MISS_W'(MAX_MISSES)) begin
            state_d     = S_OVER;
            mole_d      = {N_HOLES{1'b1}};
            game_over_d = 1'b1;
          end else begin
            state_d = S_GAP;
            mole_d  = {N_HOLES{1'b0}};
          end
        end else if (good_s) begin
          if (score_q != {SCORE_W{1'b1}}) begin
            score_d = score_q + SCORE_W'(1'b1);
          end else begin
            score_d = score_q;
          end
          hit_pulse_d = 1'b1;
          state_d     = S_GAP;
          timer_d     = {TMR_W{1'b0}};
          mole_d      = {N_HOLES{1'b0}};
        end else begin
          timer_d = timer_q + TMR_W'(1'b1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        timer_d     = {TMR_W{1'b0}};
        mole_d      = {N_HOLES{1'b0}};
        game_over_d = 1'b0;
      end
    endcase
  end

  // State, LFSR, edge register and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= {TMR_W{1'b0}};
      prev_hole_q <= {HOLE_W{1'b0}};
      lfsr_q      <= LFSR_SEED;
      hit_q       <= {N_HOLES{1'b0}};
      ready_q     <= 1'b0;
      mole_q      <= {N_HOLES{1'b0}};
      score_q     <= {SCORE_W{1'b0}};
      misses_q    <= {MISS_W{1'b0}};
      hit_pulse_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      prev_hole_q <= prev_hole_d;
      lfsr_q      <= lfsr_d;
      hit_q       <= bus.hit_in;
      ready_q     <= 1'b1;
      mole_q      <= mole_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      hit_pulse_q <= hit_pulse_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.mole_out  = mole_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.hit_pulse = hit_pulse_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_mole_game_core.sv
// tb_mole_game_core
//   Self-checking bench for mole_game_core (N_HOLES=4, SCORE_W=4, UP=16,
//   GAP=4, MAX_MISSES=3). A cycle-level reference model computes the expected
//   outputs for every driven cycle and queues them; a monitor on the falling
//   edge pops and compares them against the DUT.
module tb_mole_game_core;

  localparam int ST_IDLE = 0;
  localparam int ST_GAP  = 1;
  localparam int ST_UP   = 2;
  localparam int ST_OVER = 3;

  typedef struct {
    int         cyc;
    logic [3:0] mole;
    logic [3:0] score;
    logic [1:0] misses;
    logic       hp;
    logic       go;
    string      tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];
  exp_t mon_e;

  // reference model state
  int         m_st;
  int         m_timer;
  int         m_prev;
  logic [7:0] m_lfsr;
  logic [3:0] m_hprev;
  logic       m_ready;
  logic [3:0] m_mole;
  logic [3:0] m_score;
  logic [1:0] m_misses;
  logic       m_hp;
  logic       m_go;

  mole_game_if #(.N_HOLES(4), .SCORE_W(4), .MISS_W(2)) bif ();

  mole_game_core #(
    .N_HOLES(4), .SCORE_W(4), .UP_CYCLES(16), .GAP_CYCLES(4),
    .MAX_MISSES(3), .LFSR_SEED(8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        check_val({mon_e.tag, "/mole"},   32'(bif.mole_out),  32'(mon_e.mole));
        check_val({mon_e.tag, "/score"},  32'(bif.score),     32'(mon_e.score));
        check_val({mon_e.tag, "/misses"}, 32'(bif.misses),    32'(mon_e.misses));
        check_val({mon_e.tag, "/hpulse"}, 32'(bif.hit_pulse), 32'(mon_e.hp));
        check_val({mon_e.tag, "/gover"},  32'(bif.game_over), 32'(mon_e.go));
      end
    end
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    // taps x^8, x^6, x^5, x^4 -> bits 7,5,4,3
    logic fb;
    fb = ^(v & 8'b1011_1000);
    return (v << 1) | {7'd0, fb};
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE; m_timer = 0; m_prev = 0; m_lfsr = 8'hA5;
    m_hprev = 4'd0; m_ready = 1'b0;
    m_mole = 4'd0; m_score = 4'd0; m_misses = 2'd0; m_hp = 1'b0; m_go = 1'b0;
  endtask

  task automatic model_miss();
    m_misses = m_misses + 2'd1;
    m_timer  = 0;
    if (m_misses == 2'd3) begin
      m_st = ST_OVER; m_mole = 4'hF; m_go = 1'b1;
    end else begin
      m_st = ST_GAP; m_mole = 4'd0;
    end
  endtask

  // drive one clock cycle of inputs, advance the model, queue the expectation
  task automatic cycle(input logic s, input logic [3:0] h, input string tag);
    logic [3:0] rise;
    int         idx;
    exp_t       e;
    bif.start  = s;
    bif.hit_in = h;
    rise = h & ~m_hprev;
    m_hp = 1'b0;
    if (m_st == ST_IDLE || m_st == ST_OVER) begin
      if (s && m_ready) begin
        m_st = ST_GAP; m_timer = 0; m_score = 4'd0; m_misses = 2'd0;
        m_mole = 4'd0; m_go = 1'b0;
      end
    end else if (m_st == ST_GAP) begin
      if (m_timer == 3) begin
        idx = int'(m_lfsr) % 4;
        if (idx == m_prev) idx = (idx + 1) % 4;
        m_prev = idx; m_st = ST_UP; m_timer = 0;
        m_mole = 4'd0; m_mole[idx] = 1'b1;
      end else begin
        m_timer++;
      end
    end else begin
      if ((rise & ~m_mole) != 4'd0) model_miss();
      else if ((rise & m_mole) != 4'd0) begin
        if (m_score != 4'hF) m_score = m_score + 4'd1;
        m_hp = 1'b1; m_st = ST_GAP; m_timer = 0; m_mole = 4'd0;
      end else if (m_timer == 15) model_miss();
      else m_timer++;
    end
    m_lfsr  = lfsr_step(m_lfsr);
    m_hprev = h;
    m_ready = 1'b1;
    e.cyc = cyc + 1; e.mole = m_mole; e.score = m_score; e.misses = m_misses;
    e.hp = m_hp; e.go = m_go; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_to_up();
    for (int i = 0; i < 8 && m_st != ST_UP; i++) cycle(1'b0, 4'd0, "gap");
  endtask

  // reset release with start held high (ignored), two idle cycles, then start
  task automatic boot();
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 4'd0, "start_at_release");
    cycle(1'b0, 4'd0, "idle");
    cycle(1'b0, 4'd0, "idle");
    cycle(1'b1, 4'd0, "start");
    run_to_up();
  endtask

  initial begin
    logic [3:0] held;
    logic [3:0] other;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bif.start = 1'b0;
    bif.hit_in = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset/mole",  32'(bif.mole_out),  32'd0);
    check_val("reset/score", 32'(bif.score),     32'd0);
    check_val("reset/gover", 32'(bif.game_over), 32'd0);

    // 1) start, four gap cycles, then a single raised mole
    boot();
    cycle(1'b0, 4'd0, "up_wait");

    // 2) correct press held for 10 cycles scores once
    held = m_mole;
    repeat (10) cycle(1'b0, held, "hold_hit");
    cycle(1'b0, 4'd0, "release");

    // 3) never press: timeouts until game over
    for (int i = 0; i < 120 && m_st != ST_OVER; i++) cycle(1'b0, 4'd0, "timeout");
    repeat (3) cycle(1'b0, 4'd0, "over_hold");

    // 4) restart from OVER; correct+wrong together, then wrong alone
    cycle(1'b1, 4'd0, "restart");
    run_to_up();
    cycle(1'b1, 4'd0, "start_in_up");
    other = {m_mole[2:0], m_mole[3]};
    cycle(1'b0, m_mole | other, "dual_press");
    cycle(1'b1, 4'd0, "start_in_gap");
    run_to_up();
    other = {m_mole[2:0], m_mole[3]};
    cycle(1'b0, other, "wrong_press");
    cycle(1'b0, 4'd0, "release");

    // 5) many correct hits: score saturates at 15, holes never repeat
    for (int i = 0; i < 45; i++) begin
      run_to_up();
      cycle(1'b0, 4'd0, "up_wait");
      cycle(1'b0, m_mole, "hit");
      cycle(1'b0, 4'd0, "release");
    end

    // 6) asynchronous reset mid-UP, then the same boot sequence
    run_to_up();
    cycle(1'b0, 4'd0, "up_wait");
    sb.delete();
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst/mole",   32'(bif.mole_out),  32'd0);
    check_val("async_rst/score",  32'(bif.score),     32'd0);
    check_val("async_rst/misses", 32'(bif.misses),    32'd0);
    check_val("async_rst/hpulse", 32'(bif.hit_pulse), 32'd0);
    check_val("async_rst/gover",  32'(bif.game_over), 32'd0);
    bif.hit_in = 4'd0;
    repeat (2) @(negedge clk);
    boot();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'd0, "up_wait");
      cycle(1'b0, m_mole, "hit2");
      cycle(1'b0, 4'd0, "release");
      run_to_up();
    end

    @(negedge clk);
    #1;
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
